spi_slave_drive: RTL and testbench

SPI responder (slave) that is the far end of `spi_drive`. It oversamples the external SPI clock, chip-select and MOSI on the system clock. It deserialises each received word onto a one-cycle user strobe and serialises user-supplied words onto MISO. It supports all four CPOL/CPHL modes and sits between the SPI pins and the user logic, using the same user handshake as `spi_drive`.

---
 rtl/spi_slave_drive.sv | 141 ++++++++++++++
 tb/tb_spi_slave_drive.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_drive.sv
// SPI responder: oversamples SCLK/CS/MOSI on i_clk, deserialises words onto a
// one-cycle user strobe and serialises user words (MSB first) onto MISO.
module spi_slave_drive #(
    parameter int P_DATA_WIDTH = 8,
    parameter int P_CPOL       = 0,
    parameter int P_CPHL       = 0
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_spi_clk,
    input  logic                    i_spi_cs,
    input  logic                    i_spi_mosi,
    output logic                    o_spi_miso,
    input  logic [P_DATA_WIDTH-1:0] i_user_data,
    input  logic                    i_user_valid,
    output logic                    o_ready,
    output logic [P_DATA_WIDTH-1:0] o_user_data,
    output logic                    o_user_valid,
    output logic                    o_frame_err
);

    localparam int   W        = P_DATA_WIDTH;
    localparam int   CNT_W    = (W > 2) ? $clog2(W) : 1;
    localparam logic IDLE_LVL = 1'(P_CPOL);
    localparam bit   CPHL     = (P_CPHL != 0);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         sclk_sync;
    logic [2:0]         cs_sync;
    logic [1:0]         mosi_sync;
    logic [CNT_W-1:0]   bit_cnt;
    logic [W-1:0]       hold_data;
    logic [W-1:0]       tx_shift;
    logic [W-2:0]       rx_shift;
    logic               first_shift;

    logic               cs_fall, cs_rise, edges_on;
    logic               lead_edge, trail_edge;
    logic               sample_edge, shift_edge;
    logic               frame_start, word_load, handshake, last_bit;
    logic [W-1:0]       rx_next;

    // NOTE: synchronisers carry no reset so a CS held low through reset cannot
    // fake a falling edge on release; they flush within two cycles anyway.
    always_ff @(posedge i_clk) begin
        sclk_sync <= {sclk_sync[1:0], i_spi_clk};
        cs_sync   <= {cs_sync[1:0], i_spi_cs};
        mosi_sync <= {mosi_sync[0], i_spi_mosi};
    end

    always_comb begin
        state_d     = state_q;
        cs_fall     = cs_sync[2] & ~cs_sync[1];
        cs_rise     = ~cs_sync[2] & cs_sync[1];
        edges_on    = (state_q == ACTIVE) && !cs_sync[1];
        lead_edge   = (sclk_sync[2] == IDLE_LVL) && (sclk_sync[1] != IDLE_LVL);
        trail_edge  = (sclk_sync[2] != IDLE_LVL) && (sclk_sync[1] == IDLE_LVL);
        sample_edge = edges_on && (CPHL ? trail_edge : lead_edge);
        shift_edge  = edges_on && (CPHL ? lead_edge : trail_edge);
        frame_start = (state_q == IDLE) && cs_fall;
        // With CPHL=1 the first leading edge precedes any sample, so the word
        // loaded at CS fall must stay on MISO through it.
        word_load   = frame_start ||
                      (shift_edge && (bit_cnt == '0) && !(CPHL && first_shift));
        handshake   = i_user_valid && o_ready;
        last_bit    = (bit_cnt == CNT_W'(W - 1));
        rx_next     = {rx_shift, mosi_sync[1]};

        case (state_q)
            IDLE:    if (cs_fall) state_d = ACTIVE;
            ACTIVE:  if (cs_rise) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: all state updates use non-blocking assignments so every register
    // sees the same pre-edge values regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= IDLE;
            bit_cnt      <= '0;
            hold_data    <= '0;
            o_ready      <= 1'b1;
            tx_shift     <= '0;
            rx_shift     <= '0;
            first_shift  <= 1'b0;
            o_user_data  <= '0;
            o_user_valid <= 1'b0;
            o_frame_err  <= 1'b0;
        end else begin
            state_q      <= state_d;
            o_user_valid <= 1'b0;
            o_frame_err  <= 1'b0;

            // Holding register: a coincident handshake wins, so new data stays.
            if (handshake) begin
                hold_data <= i_user_data;
                o_ready   <= 1'b0;
            end else if (word_load) begin
                o_ready   <= 1'b1;
            end

            if (frame_start) begin
                first_shift <= 1'b1;
            end else if (shift_edge) begin
                first_shift <= 1'b0;
            end

            if (word_load) begin
                tx_shift <= o_ready ? '1 : hold_data;
            end else if (shift_edge && !(CPHL && first_shift)) begin
                tx_shift <= {tx_shift[W-2:0], 1'b0};
            end

            if (sample_edge) begin
                rx_shift <= rx_next[W-2:0];
                if (last_bit) begin
                    o_user_data  <= rx_next;
                    o_user_valid <= 1'b1;
                    bit_cnt      <= '0;
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end

            if ((state_q == ACTIVE) && cs_rise) begin
                o_frame_err <= (bit_cnt != '0);
                bit_cnt     <= '0;
                tx_shift    <= '0;
            end
        end
    end

    assign o_spi_miso = (state_q == ACTIVE) && tx_shift[W-1];

endmodule

// File: tb/tb_spi_slave_drive.sv
// Directed bench: one responder per SPI mode, driven by a behavioural master.
module tb_spi_slave_drive;

    localparam int HALF = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] sclk = 4'b1100;
    logic [3:0] cs = 4'b1111;
    logic [3:0] mosi = 4'b0000;
    logic [3:0] miso;
    logic [3:0] uvalid = 4'b0000;
    logic [7:0] udata = 8'h00;
    logic [3:0] ready;
    logic [3:0] ovalid;
    logic [3:0] ferr;
    logic [7:0] odata [4];

    int n_tests = 0;
    int n_fail  = 0;
    int vcnt [4];
    int fcnt [4];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        spi_slave_drive #(
            .P_DATA_WIDTH(8),
            .P_CPOL      (g / 2),
            .P_CPHL      (g % 2)
        ) dut (
            .i_clk       (clk),
            .i_rst       (rst),
            .i_spi_clk   (sclk[g]),
            .i_spi_cs    (cs[g]),
            .i_spi_mosi  (mosi[g]),
            .o_spi_miso  (miso[g]),
            .i_user_data (udata),
            .i_user_valid(uvalid[g]),
            .o_ready     (ready[g]),
            .o_user_data (odata[g]),
            .o_user_valid(ovalid[g]),
            .o_frame_err (ferr[g])
        );
    end

    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (ovalid[k]) vcnt[k] <= vcnt[k] + 1;
            if (ferr[k])   fcnt[k] <= fcnt[k] + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic put_word(input int m, input logic [7:0] d);
        int n = 0;
        @(negedge clk);
        udata     = d;
        uvalid[m] = 1'b1;
        while (!ready[m] && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) check("put_word_timeout", 32'(n), 0);
        @(negedge clk);
        uvalid[m] = 1'b0;
    endtask

    task automatic cs_assert(input int m);
        @(negedge clk);
        cs[m] = 1'b0;
        wait_clk(8);
    endtask

    task automatic cs_release(input int m);
        wait_clk(8);
        cs[m] = 1'b1;
        wait_clk(8);
    endtask

    // Master side of one word: MSB first, nbits clock cycles.
    task automatic spi_word(input int m, input logic [7:0] tx, input int nbits,
                            output logic [7:0] rx);
        logic pol = (m >= 2);
        logic pha = (m % 2 != 0);
        rx = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            if (!pha) begin
                mosi[m] = tx[7-i];
                wait_clk(HALF);
                rx = {rx[6:0], miso[m]};
                sclk[m] = ~pol;
                wait_clk(HALF);
                sclk[m] = pol;
            end else begin
                sclk[m] = ~pol;
                mosi[m] = tx[7-i];
                wait_clk(HALF);
                rx = {rx[6:0], miso[m]};
                sclk[m] = pol;
                wait_clk(HALF);
            end
        end
    endtask

    initial begin
        logic [7:0] rx, rx2, d_tx, d_sl;
        int v0, f0;

        wait_clk(5);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready",  32'(ready), 32'hF);
        check("rst_miso",   32'(miso), 0);
        check("rst_valid",  32'(ovalid), 0);
        check("rst_ferr",   32'(ferr), 0);
        check("rst_odata",  32'(odata[0]), 0);

        // Mode 0 single word
        put_word(0, 8'hA5);
        check("m0_ready_low", 32'(ready[0]), 0);
        v0 = vcnt[0];
        cs_assert(0);
        check("m0_ready_cs_fall", 32'(ready[0]), 1);
        spi_word(0, 8'h55, 8, rx);
        cs_release(0);
        check("m0_master_rx", 32'(rx), 32'hA5);
        check("m0_slave_rx",  32'(odata[0]), 32'h55);
        check("m0_valid_cnt", 32'(vcnt[0] - v0), 1);

        // Underrun
        v0 = vcnt[0];
        cs_assert(0);
        spi_word(0, 8'h3C, 8, rx);
        cs_release(0);
        check("ur_master_rx", 32'(rx), 32'hFF);
        check("ur_slave_rx",  32'(odata[0]), 32'h3C);
        check("ur_valid_cnt", 32'(vcnt[0] - v0), 1);

        // Two-word frame, mode 3
        put_word(3, 8'h12);
        v0 = vcnt[3];
        cs_assert(3);
        put_word(3, 8'h34);
        check("m3_ready_held", 32'(ready[3]), 0);
        spi_word(3, 8'h81, 8, rx);
        wait_clk(2);
        check("m3_w1_slave_rx", 32'(odata[3]), 32'h81);
        check("m3_w1_valid",    32'(vcnt[3] - v0), 1);
        spi_word(3, 8'h7E, 8, rx2);
        cs_release(3);
        check("m3_w2_slave_rx", 32'(odata[3]), 32'h7E);
        check("m3_w2_valid",    32'(vcnt[3] - v0), 2);
        check("m3_w1_master",   32'(rx), 32'h12);
        check("m3_w2_master",   32'(rx2), 32'h34);

        // Aborted word then a clean frame
        v0 = vcnt[0];
        f0 = fcnt[0];
        cs_assert(0);
        spi_word(0, 8'hC3, 5, rx);
        cs_release(0);
        check("ab_ferr_cnt",  32'(fcnt[0] - f0), 1);
        check("ab_valid_cnt", 32'(vcnt[0] - v0), 0);
        cs_assert(0);
        spi_word(0, 8'h99, 8, rx);
        cs_release(0);
        check("ab_next_rx",    32'(odata[0]), 32'h99);
        check("ab_next_valid", 32'(vcnt[0] - v0), 1);
        check("ab_next_ferr",  32'(fcnt[0] - f0), 1);

        // Reset mid-frame with CS held low
        cs_assert(0);
        put_word(0, 8'h77);
        spi_word(0, 8'hFF, 3, rx);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rm_miso",  32'(miso[0]), 0);
        check("rm_ready", 32'(ready[0]), 1);
        check("rm_odata", 32'(odata[0]), 0);
        check("rm_valid", 32'(ovalid[0]), 0);
        check("rm_ferr",  32'(ferr[0]), 0);
        v0 = vcnt[0];
        f0 = fcnt[0];
        spi_word(0, 8'hFF, 8, rx);
        cs_release(0);
        check("rm_no_valid", 32'(vcnt[0] - v0), 0);
        check("rm_no_ferr",  32'(fcnt[0] - f0), 0);
        cs_assert(0);
        spi_word(0, 8'hF0, 8, rx);
        cs_release(0);
        check("rm_next_rx",    32'(odata[0]), 32'hF0);
        check("rm_next_valid", 32'(vcnt[0] - v0), 1);
        check("rm_next_miso",  32'(rx), 32'hFF);

        // Loopback, all four modes
        for (int m = 0; m < 4; m++) begin
            for (int k = 0; k < 64; k++) begin
                d_tx = 8'($urandom);
                d_sl = 8'($urandom);
                put_word(m, d_sl);
                v0 = vcnt[m];
                cs_assert(m);
                spi_word(m, d_tx, 8, rx);
                cs_release(m);
                check($sformatf("lb_m%0d_miso", m), 32'(rx), 32'(d_sl));
                check($sformatf("lb_m%0d_mosi", m), 32'(odata[m]), 32'(d_tx));
                check($sformatf("lb_m%0d_valid", m), 32'(vcnt[m] - v0), 1);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
